// File: rtl/div_sequencer_pkg.sv
// div_sequencer_pkg: shared encodings and helpers for the RV32M divide sequencer.
//   - func3 encodings for DIV/DIVU/REM/REMU
//   - 2-bit FSM state encodings
//   - R-type opcode / MULDIV funct7 (decoded upstream to raise `start`)
//   - latched per-operation control struct and special-case helpers
package div_sequencer_pkg;

  localparam logic [2:0] DIV_F3_DIV  = 3'b100;
  localparam logic [2:0] DIV_F3_DIVU = 3'b101;
  localparam logic [2:0] DIV_F3_REM  = 3'b110;
  localparam logic [2:0] DIV_F3_REMU = 3'b111;

  localparam logic [1:0] DIV_ST_IDLE = 2'd0;
  localparam logic [1:0] DIV_ST_CALC = 2'd1;
  localparam logic [1:0] DIV_ST_FIX  = 2'd2;
  localparam logic [1:0] DIV_ST_DONE = 2'd3;

  localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Everything about the accepted instruction that FIX still needs.
  typedef struct packed {
    logic is_signed;
    logic sel_rem;
    logic sign_a;
    logic sign_b;
    logic div0;
    logic ovf;
  } div_ctl_t;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  // Result of a divide-by-zero or signed-overflow operation.
  function automatic logic [31:0] special_result(input logic sel_rem, input logic div0,
                                                 input logic [31:0] dividend);
    if (div0) return sel_rem ? dividend : 32'hFFFF_FFFF;
    return sel_rem ? 32'h0 : 32'h8000_0000;
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// div_iter_step: one combinational restoring-division iteration.
//   rem_i/quo_i : current 33-bit partial remainder and 32-bit quotient shift reg
//   divisor_i   : 32-bit (unsigned magnitude) divisor
//   rem_o/quo_o : values after shifting {rem,quo} left and trial-subtracting
module div_iter_step (
  input  logic [32:0] rem_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] divisor_i,
  output logic [32:0] rem_o,
  output logic [31:0] quo_o
);

  logic [33:0] shifted;
  logic [33:0] diff;
  logic [33:0] nxt;
  logic        unused_nxt_msb;

  assign shifted = {rem_i, quo_i[31]};
  assign diff    = shifted - {2'b00, divisor_i};

  always_comb begin
    nxt   = shifted;
    quo_o = {quo_i[30:0], 1'b0};
    if (shifted >= {2'b00, divisor_i}) begin
      nxt   = diff;
      quo_o = {quo_i[30:0], 1'b1};
    end
  end

  // The remainder stays below the divisor, so the top bit never carries.
  assign rem_o          = nxt[32:0];
  assign unused_nxt_msb = nxt[33];

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M DIV/DIVU/REM/REMU sequencer (32-step restoring).
//   clk, rst_n      : clock, async active-low reset
//   start, func3    : EX holds a divide-class instruction / its func3
//   op_a, op_b      : dividend (rs1), divisor (rs2)
//   flush           : abandon the in-flight operation
//   busy            : combinational stall request
//   result          : registered quotient/remainder
//   result_valid    : one-cycle strobe in DONE
// Config macro DIV_FASTPATH_EN: resolve div-by-zero / signed overflow in IDLE
// and jump straight to DONE (result_valid the cycle after acceptance).
module div_sequencer
  import div_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  func3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] result,
  output logic        result_valid
);

  logic [1:0]  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] result_q, result_d;
  div_ctl_t    ctl_q, ctl_d;

  logic [32:0] step_rem;
  logic [31:0] step_quo;
  logic        unused_rem_msb;
  div_ctl_t    new_ctl;
  logic [31:0] q_fix, r_fix;

  div_iter_step u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  assign unused_rem_msb = rem_q[32];

  // Decode of the incoming instruction; unknown func3 codes behave as DIVU.
  always_comb begin
    new_ctl           = '0;
    new_ctl.is_signed = (func3 == DIV_F3_DIV) || (func3 == DIV_F3_REM);
    new_ctl.sel_rem   = (func3 == DIV_F3_REM) || (func3 == DIV_F3_REMU);
    new_ctl.sign_a    = new_ctl.is_signed & op_a[31];
    new_ctl.sign_b    = new_ctl.is_signed & op_b[31];
    new_ctl.div0      = (op_b == 32'h0);
    new_ctl.ovf       = new_ctl.is_signed & (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);
  end

  // Sign fix-up. With a zero divisor the iterations leave |a| in rem, so the
  // dividend-sign rule already reproduces op_a as the remainder.
  always_comb begin
    q_fix = cond_neg(quo_q, (ctl_q.sign_a ^ ctl_q.sign_b) & ~ctl_q.div0);
    r_fix = cond_neg(rem_q[31:0], ctl_q.sign_a);
    if (ctl_q.div0) begin
      q_fix = 32'hFFFF_FFFF;
    end else if (ctl_q.ovf) begin
      q_fix = 32'h8000_0000;
      r_fix = 32'h0;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    ctl_d     = ctl_q;
    case (state_q)
      DIV_ST_IDLE: begin
        if (start && !flush) begin
          ctl_d     = new_ctl;
          quo_d     = cond_neg(op_a, new_ctl.sign_a);
          divisor_d = cond_neg(op_b, new_ctl.sign_b);
          rem_d     = '0;
          count_d   = '0;
          state_d   = DIV_ST_CALC;
`ifdef DIV_FASTPATH_EN
          if (new_ctl.div0 || new_ctl.ovf) begin
            result_d = special_result(new_ctl.sel_rem, new_ctl.div0, op_a);
            state_d  = DIV_ST_DONE;
          end
`endif
        end
      end
      DIV_ST_CALC: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) state_d = DIV_ST_FIX;
      end
      DIV_ST_FIX: begin
        result_d = ctl_q.sel_rem ? r_fix : q_fix;
        state_d  = DIV_ST_DONE;
      end
      default: state_d = DIV_ST_IDLE;
    endcase
    // Flush beats everything, including a result load in FIX.
    if (flush) begin
      state_d  = DIV_ST_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DIV_ST_IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      ctl_q     <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
      ctl_q     <= ctl_d;
    end
  end

  assign busy         = ((state_q == DIV_ST_IDLE) & start & ~flush) |
                        (state_q == DIV_ST_CALC) | (state_q == DIV_ST_FIX);
  assign result       = result_q;
  assign result_valid = (state_q == DIV_ST_DONE);

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: randomized + directed bench for div_sequencer, checked
// every cycle against an arithmetic/timing reference model.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

`ifdef DIV_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  div_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func3(func3), .op_a(op_a),
    .op_b(op_b), .flush(flush), .busy(busy), .result(result),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit is_sgn(input logic [2:0] f3);
    return (f3 == 3'b100) || (f3 == 3'b110);
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (is_sgn(f3) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RISC-V divide semantics straight from the ISA rules.
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (is_sgn(f3) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0;
    end else if (is_sgn(f3)) begin
      q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
    end else begin
      q = a / b; r = a % b;
    end
    return (f3 == 3'b110 || f3 == 3'b111) ? r : q;
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return (FAST && is_special(f3, a, b)) ? 1 : 34;
  endfunction

  // Reference model: one pending op with accept cycle, latency and value.
  bit          m_pend = 0;
  int          m_tacc, m_lat;
  logic [31:0] m_val, m_last = 0;

  always @(negedge clk) begin
    logic exp_busy, exp_valid;
    logic [31:0] exp_res;
    bit idle;
    if (!rst_n) begin
      m_pend = 0; m_last = 0;
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_valid", {31'b0, result_valid}, 0);
      chk("rst_result", result, 0);
    end else begin
      exp_valid = m_pend && (cyc == m_tacc + m_lat);
      exp_busy  = (m_pend && cyc < m_tacc + m_lat) || (!m_pend && start && !flush);
      exp_res   = exp_valid ? m_val : m_last;
      chk("busy", {31'b0, busy}, {31'b0, exp_busy});
      chk("result_valid", {31'b0, result_valid}, {31'b0, exp_valid});
      chk("result", result, exp_res);
      if (exp_valid) m_last = m_val;
      idle = !m_pend;
      if (m_pend && cyc >= m_tacc + m_lat) m_pend = 0;
      if (flush) m_pend = 0;
      else if (idle && start) begin
        m_pend = 1; m_tacc = cyc;
        m_val  = ref_div(func3, op_a, op_b);
        m_lat  = ref_lat(func3, op_a, op_b);
      end
    end
  end

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, output int t0);
    @(posedge clk); #1;
    start = 1; func3 = f3; op_a = a; op_b = b; t0 = cyc;
    @(posedge clk); #1;
    start = 0; func3 = $urandom; op_a = $urandom; op_b = $urandom;
  endtask

  task automatic run(input string nm, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int t0, lat;
    bit got;
    logic [31:0] r;
    issue(f3, a, b, t0);
    got = 0; lat = -1; r = 'x;
    for (int i = 0; i < 60 && !got; i++) begin
      if (i > 0 || !FAST) @(negedge clk);
      else @(negedge clk);
      if (result_valid) begin got = 1; lat = cyc - t0; r = result; end
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL %s timeout: no result_valid within 60 cycles", nm);
    end else begin
      chk({nm, "_val"}, r, exp);
      chk({nm, "_lat"}, lat, exp_lat);
    end
  endtask

  initial begin
    int t0;
    rst_n = 0; start = 0; flush = 0; func3 = 0; op_a = 0; op_b = 0;

    // pin the reference model itself
    chk("pin_divu", ref_div(3'b101, 100, 7), 14);
    chk("pin_rem_neg", ref_div(3'b110, 32'hFFFF_FF9C, 7), 32'hFFFF_FFFE);
    chk("pin_div0", ref_div(3'b100, 5, 0), 32'hFFFF_FFFF);

    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    run("divu_100_7", 3'b101, 100, 7, 14, 34);
    run("remu_100_7", 3'b111, 100, 7, 2, 34);
    run("div_m100_7", 3'b100, 32'hFFFF_FF9C, 7, 32'hFFFF_FFF2, 34);
    run("rem_m100_7", 3'b110, 32'hFFFF_FF9C, 7, 32'hFFFF_FFFE, 34);
    run("divu_5_0", 3'b101, 5, 0, 32'hFFFF_FFFF, FAST ? 1 : 34);
    run("rem_5_0", 3'b110, 5, 0, 5, FAST ? 1 : 34);
    run("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FAST ? 1 : 34);
    run("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0, FAST ? 1 : 34);
    run("f3_other", 3'b010, 100, 7, 14, 34);

    // flush in T+10, new start in T+11
    issue(3'b101, 1000, 9, t0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1;
    @(posedge clk); #1;
    flush = 0; start = 1; func3 = 3'b100; op_a = 32'hFFFF_F000; op_b = 13;
    @(posedge clk); #1;
    start = 0;
    repeat (40) begin @(posedge clk); #1; end

    // flush together with start in IDLE: nothing accepted
    start = 1; flush = 1; func3 = 3'b101; op_a = 50; op_b = 5;
    @(posedge clk); #1;
    start = 0; flush = 0;
    repeat (3) begin @(posedge clk); #1; end

    // start pulses during CALC are ignored
    issue(3'b111, 32'hDEAD_BEEF, 12345, t0);
    for (int i = 0; i < 20; i++) begin
      start = i[0]; func3 = $urandom; op_a = $urandom; op_b = $urandom;
      @(posedge clk); #1;
    end
    start = 0;
    repeat (20) begin @(posedge clk); #1; end

    // reset at T+5
    issue(3'b101, 1000, 3, t0);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1;
    repeat (40) begin @(posedge clk); #1; end

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 60) == 0);
      func3 = $urandom_range(0, 7);
      op_a  = rnd_op();
      op_b  = rnd_op();
    end
    @(posedge clk); #1;
    start = 0; flush = 0;
    repeat (40) begin @(posedge clk); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
